timer_compare_irq: RTL
======================

# timer_compare_irq

Alarm and interrupt stage that sits directly downstream of the custom timer counter peripheral on the Nios II Avalon-MM bus. It samples the counter's 32-bit count and compares it against a software-programmed compare value. On a match it latches a sticky HIT flag and asserts a level interrupt to the CPU. It supports one-shot and periodic (auto-reload) alarms.

## Interface
Parameters:
- MISSED_W, 8, width of the saturating missed-event counter (1..8).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- count_in  in  32  count value from the upstream timer counter.
- count_en  in  1  high while the upstream counter is enabled (its CTRL[0]).
- address  in  2  register select: 0=CTRL, 1=COMPARE, 2=PERIOD, 3=STATUS.
- read  in  1  Avalon-MM read strobe.
- write  in  1  Avalon-MM write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data; combinational, 0 when read=0.
- irq  out  1  level interrupt = HIT & IRQ_EN.

## Operation
- CTRL (RW): bit0 ARM, bit1 PERIODIC, bit2 IRQ_EN; all other bits read 0.
- COMPARE (RW): programmed match value. A write also loads the active compare, cmp_act.
- PERIOD (RW): reload increment for periodic mode.
- STATUS:
  - bit0 HIT: write 1 to clear.
  - bits[8+MISSED_W-1:8] MISSED: read-only; cleared by writing STATUS with bit1=1.
  - bits[17:16] state: 0=IDLE, 1=ARMED, 2=FIRED; read-only.
- State machine:
  - IDLE -> ARMED on a CTRL write with ARM=1; cmp_act loads from COMPARE.
  - ARMED -> ARMED on a match when PERIODIC=1; cmp_act <= cmp_act + PERIOD, mod 2^32, wrap allowed.
  - ARMED -> FIRED on a match when PERIODIC=0; the ARM bit clears in hardware.
  - Any state -> IDLE on a CTRL write with ARM=0.
  - FIRED -> ARMED on a CTRL write with ARM=1.
- Match condition: state==ARMED, count_en=1, and count_in==cmp_act. Equality only; a count that skips past cmp_act never fires.
- On a match: HIT <= 1. If HIT was already 1, MISSED increments, saturating at 2^MISSED_W-1.
- PERIOD=0 in periodic mode: cmp_act is unchanged, so the block refires every cycle count_in holds that value.
- Unmapped reads return 0. Writes to STATUS bits other than 0 and 1 are ignored.

## Timing
- Reset values: all registers 0, state IDLE, cmp_act 0, HIT 0, MISSED 0, irq 0, readdata 0.
- Match latency: count_in matches in cycle N -> HIT=1 and irq=1 (if IRQ_EN) in cycle N+1.
- Register writes take effect at the clock edge ending the write cycle. Reads return the post-edge values from the next cycle onward.
- Simultaneous match and HIT W1C in the same cycle: set wins, HIT stays 1, MISSED unchanged.
- Simultaneous match and COMPARE write:
  - The match is evaluated against the old cmp_act.
  - The new cmp_act is the written value; the periodic reload is discarded.
- Simultaneous match and CTRL write with ARM=0: HIT sets, and state goes to IDLE.
- Simultaneous match and MISSED clear: MISSED = 0.
- Asynchronous reset mid-operation clears everything immediately; irq deasserts without waiting for a clock edge.

## Configuration
- TIMER_CMP_MISSED_CNT_EN:
  - Defined: the MISSED counter and its clear are implemented.
  - Undefined: MISSED bits always read 0, STATUS bit1 writes are ignored, and no counter flops are synthesized.
- HIT and irq behaviour are identical in both builds.

## Test plan
- One-shot: COMPARE=100, CTRL=0x5, count_in ramps from 0 with count_en=1 -> irq rises the cycle after count_in=100; STATUS reads 0x20001; CTRL reads 0x4.
- Periodic wrap: COMPARE=0xFFFFFFF0, PERIOD=0x20, CTRL=0x7 -> hits at 0xFFFFFFF0, then 0x10, then 0x30; clear HIT between hits; irq pulses each time.
- Missed events (macro on): periodic with PERIOD=10, HIT never cleared, 300 matches -> MISSED reads 255 and saturates; writing STATUS=0x2 makes it read 0.
- Set-vs-clear collision: write STATUS=1 in the exact match cycle -> HIT remains 1, irq stays high, MISSED unchanged.
- Gating: count_en=0 while count_in equals COMPARE -> no HIT. Disarm with CTRL=0 before the match -> no HIT, state reads IDLE.
- Async reset asserted with irq=1 -> irq and readdata go 0 before the next clk edge; all registers read 0 after release.

Source files
------------

// File: rtl/timer_compare_irq_if.sv
// timer_compare_irq_if
//   Avalon-MM slave register bus for the timer compare/alarm stage.
//   Signals:
//     address   [1:0]  register select (0=CTRL, 1=COMPARE, 2=PERIOD, 3=STATUS)
//     read             read strobe
//     write            write strobe
//     writedata [31:0] write data
//     readdata  [31:0] read data (combinational, 0 when read is low)
//   Modports: master drives the strobes, slave returns readdata.
interface timer_compare_irq_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/timer_compare_irq.sv
// timer_compare_irq
//   Alarm stage behind the timer counter. Compares the counter value with a
//   software-programmed compare value, latches a sticky HIT flag and raises a
//   level interrupt. Supports one-shot and periodic (auto-reload) alarms.
//
//   Parameters:
//     MISSED_W  width of the saturating missed-event counter (1..8)
//   Optional build macro:
//     TIMER_CMP_MISSED_CNT_EN  when defined, implements the MISSED counter and
//                              its clear; otherwise MISSED reads 0.
//   Ports:
//     clk       system clock
//     reset     asynchronous, active-low reset
//     count_in  count value from the upstream timer counter
//     count_en  upstream counter enable
//     bus       register bus (slave modport)
//     irq       level interrupt = HIT & IRQ_EN
module timer_compare_irq #(
  parameter int MISSED_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          count_in,
  input  logic                 count_en,
  timer_compare_irq_if.slave   bus,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] compare_reg, compare_next;
  logic [31:0] period_reg, period_next;
  logic [31:0] cmp_act_reg, cmp_act_next;
  logic        periodic_reg, periodic_next;
  logic        irq_en_reg, irq_en_next;
  logic        hit_reg, hit_next;
`ifdef TIMER_CMP_MISSED_CNT_EN
  logic [MISSED_W-1:0] missed_reg, missed_next;
`endif

  logic        ctrl_wr, cmp_wr, per_wr, stat_wr;
  logic        hit_clr;
  logic        match;
  logic [31:0] status_word;
  logic [31:0] read_mux;

  assign ctrl_wr = bus.write && (bus.address == 2'd0);
  assign cmp_wr  = bus.write && (bus.address == 2'd1);
  assign per_wr  = bus.write && (bus.address == 2'd2);
  assign stat_wr = bus.write && (bus.address == 2'd3);
  assign hit_clr = stat_wr && bus.writedata[0];

  // Strict equality against the active compare; a counter that steps over
  // cmp_act never fires.
  assign match = (state_reg == ST_ARMED) && count_en && (count_in == cmp_act_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      compare_reg  <= '0;
      period_reg   <= '0;
      cmp_act_reg  <= '0;
      periodic_reg <= 1'b0;
      irq_en_reg   <= 1'b0;
      hit_reg      <= 1'b0;
`ifdef TIMER_CMP_MISSED_CNT_EN
      missed_reg   <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      compare_reg  <= compare_next;
      period_reg   <= period_next;
      cmp_act_reg  <= cmp_act_next;
      periodic_reg <= periodic_next;
      irq_en_reg   <= irq_en_next;
      hit_reg      <= hit_next;
`ifdef TIMER_CMP_MISSED_CNT_EN
      missed_reg   <= missed_next;
`endif
    end
  end

  // Next-state logic. Later assignments take priority: bus writes override
  // the alarm's own state/reload decision.
  always_comb begin
    state_next    = state_reg;
    compare_next  = compare_reg;
    period_next   = period_reg;
    cmp_act_next  = cmp_act_reg;
    periodic_next = periodic_reg;
    irq_en_next   = irq_en_reg;
    hit_next      = hit_reg;

    if (match) begin
      if (periodic_reg) begin
        cmp_act_next = cmp_act_reg + period_reg;  // wraps mod 2^32
      end else begin
        state_next = ST_FIRED;
      end
    end

    // Set beats clear when a match lands on a HIT write-1-to-clear.
    if (match) begin
      hit_next = 1'b1;
    end else if (hit_clr) begin
      hit_next = 1'b0;
    end

    if (ctrl_wr) begin
      periodic_next = bus.writedata[1];
      irq_en_next   = bus.writedata[2];
      if (bus.writedata[0]) begin
        // Re-writing ARM while already armed keeps the running alarm.
        if (state_reg != ST_ARMED) begin
          cmp_act_next = compare_reg;
        end
        state_next = ST_ARMED;
      end else begin
        state_next = ST_IDLE;
      end
    end

    // A COMPARE write replaces cmp_act, discarding any same-cycle reload.
    if (cmp_wr) begin
      compare_next = bus.writedata;
      cmp_act_next = bus.writedata;
    end

    if (per_wr) begin
      period_next = bus.writedata;
    end
  end

`ifdef TIMER_CMP_MISSED_CNT_EN
  // Counts matches that arrive while HIT is still pending. A same-cycle HIT
  // clear means software has serviced it, so no event is counted; an explicit
  // MISSED clear always wins.
  always_comb begin
    missed_next = missed_reg;
    if (stat_wr && bus.writedata[1]) begin
      missed_next = '0;
    end else if (match && hit_reg && !hit_clr && (missed_reg != '1)) begin
      missed_next = missed_reg + MISSED_W'(1);
    end
  end
`endif

  always_comb begin
    status_word        = '0;
    status_word[0]     = hit_reg;
    status_word[17:16] = state_reg;
`ifdef TIMER_CMP_MISSED_CNT_EN
    status_word[8 +: MISSED_W] = missed_reg;
`else
    status_word[8 +: MISSED_W] = '0;
`endif
  end

  always_comb begin
    read_mux = '0;
    if (bus.read) begin
      case (bus.address)
        2'd0:    read_mux = {29'd0, irq_en_reg, periodic_reg, (state_reg == ST_ARMED)};
        2'd1:    read_mux = compare_reg;
        2'd2:    read_mux = period_reg;
        default: read_mux = status_word;
      endcase
    end
  end

  assign bus.readdata = read_mux;
  assign irq          = hit_reg & irq_en_reg;

endmodule
